// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared state encoding, checksum width and image format constants
package mips_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_BYTE  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;
  localparam int BYTE_W = 8;
  localparam int BPW    = 4;
  localparam int WORD_W = BYTE_W * BPW;
  localparam int CHK_W  = 8;
  localparam int LEN_W  = 8;
  function automatic logic len_ok(input logic [LEN_W-1:0] l, input int depth);
    return l != '0 && int'(l) <= depth;
  endfunction
endpackage

// File: rtl/mips_loader_word_packer.sv
// word_packer: 8-to-32 big-endian shift register with byte counter and full flag
//   CLK/RST_N clock and async active-low reset; shift loads din into the low byte;
//   clr empties the register; word is the packed word, cnt the bytes held, full at 4 bytes
module word_packer
  import mips_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              shift,
  input  logic              clr,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        cnt,
  output logic              full
);
  assign full = cnt == 3'(BPW);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift) begin
      word <= {word[WORD_W-BYTE_W-1:0], din};
      cnt  <= cnt + 3'd1;
    end
  end
endmodule

// File: rtl/mips_loader.sv
// mips_loader: loads a checksummed byte-stream image into word memory, holding the CPU in reset
//   CLK/RST_N clock and async active-low reset; START begins a load from IDLE/DONE/ERR
//   RX_VALID/RX_DATA/RX_READY byte stream handshake; CPU_RST high until the image verifies
//   CS/WE/ADDR/Mem_Bus memory write port, bus driven only while CS&WE
//   DONE image loaded and verified; ERR bad length or checksum
module mips_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DEPTH     = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              RX_VALID,
  input  logic [BYTE_W-1:0] RX_DATA,
  output logic              RX_READY,
  output logic              CPU_RST,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [WORD_W-1:0] Mem_Bus,
  output logic              DONE,
  output logic              ERR
);
  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   word_idx;
  logic [CHK_W-1:0]   xor_acc;
  logic [WORD_W-1:0]  pk_word;
  logic [2:0]         pk_cnt;
  logic               pk_full;
  logic               acc;
  logic               chk_ok;
  assign acc    = RX_VALID & RX_READY;
  assign chk_ok = RX_DATA == xor_acc;
  word_packer u_pk (
    .CLK   (CLK),
    .RST_N (RST_N),
    .shift (acc && state == S_BYTE),
    .clr   (state == S_WRITE || (acc && state == S_LEN)),
    .din   (RX_DATA),
    .word  (pk_word),
    .cnt   (pk_cnt),
    .full  (pk_full)
  );
  // The packer holds its word through WRITE because no byte is accepted there
  assign Mem_Bus = (CS && WE) ? pk_word : 'z;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      RX_READY <= 1'b0;
      CPU_RST  <= 1'b1;
      CS       <= 1'b0;
      WE       <= 1'b0;
      ADDR     <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      len      <= '0;
      word_idx <= '0;
      xor_acc  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (START) begin
          state    <= S_LEN;
          RX_READY <= 1'b1;
          CPU_RST  <= 1'b1;
          DONE     <= 1'b0;
          ERR      <= 1'b0;
        end
        S_LEN: if (acc) begin
          if (len_ok(RX_DATA, DEPTH)) begin
            state    <= S_BYTE;
            len      <= RX_DATA;
            word_idx <= '0;
            xor_acc  <= '0;
          end else begin
            state    <= S_ERR;
            RX_READY <= 1'b0;
            ERR      <= 1'b1;
          end
        end
        S_BYTE: if (acc) begin
          xor_acc <= xor_acc ^ RX_DATA;
          if (pk_cnt == 3'(BPW - 1)) begin
            state    <= S_WRITE;
            RX_READY <= 1'b0;
            CS       <= 1'b1;
            WE       <= 1'b1;
            ADDR     <= ADDR_W'(BASE_ADDR + int'(word_idx));
          end
        end
        S_WRITE: if (pk_full) begin
          CS       <= 1'b0;
          WE       <= 1'b0;
          RX_READY <= 1'b1;
          word_idx <= word_idx + 8'd1;
          state    <= (word_idx == len - 8'd1) ? S_CHK : S_BYTE;
        end
        S_CHK: if (acc) begin
          RX_READY <= 1'b0;
          state    <= chk_ok ? S_DONE : S_ERR;
          DONE     <= chk_ok;
          ERR      <= !chk_ok;
          CPU_RST  <= !chk_ok;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_loader.sv
// tb_mips_loader: directed scoreboard bench for mips_loader with immediate-assertion checks
module tb_mips_loader;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        RX_VALID = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_READY, CPU_RST, CS, WE, DONE, ERR;
  logic [6:0]  ADDR;
  wire  [31:0] Mem_Bus;
  int          n_asserts = 0;
  int          n_fails = 0;
  int          cyc = 0;
  logic [38:0] sb[$];
  logic [31:0] words[0:127];
  logic [31:0] mem[0:127];
  mips_loader dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .RX_READY(RX_READY), .CPU_RST(CPU_RST), .CS(CS), .WE(WE), .ADDR(ADDR),
    .Mem_Bus(Mem_Bus), .DONE(DONE), .ERR(ERR)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Memory side: every write strobe must match the next scoreboard entry
  always @(negedge CLK) begin
    if (CS === 1'b1) begin
      chk("rdy_low_on_write", {31'd0, RX_READY}, 32'd0);
      chk("we_with_cs", {31'd0, WE}, 32'd1);
      chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        logic [38:0] e;
        e = sb.pop_front();
        chk("wr_addr", {25'd0, ADDR}, {25'd0, e[38:32]});
        chk("wr_data", Mem_Bus, e[31:0]);
      end
      mem[ADDR] <= Mem_Bus;
    end
  end
  task automatic send(input logic [7:0] b, input bit gaps, output int c);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      RX_VALID = 1'b0;
      START = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    START = 1'b0;
    RX_VALID = 1'b1;
    RX_DATA = b;
    while (!RX_READY && t < 200) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("rx_ready_wait", {31'd0, RX_READY}, 32'd1);
    @(posedge CLK); #1;
    c = cyc;
    RX_VALID = 1'b0;
  endtask
  task automatic load(input int n, input bit gaps, input bit bad, output int c0, output int c1);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    int d;
    send(8'(n), gaps, c0);
    for (int i = 0; i < n; i++) begin
      sb.push_back({7'(i), words[i]});
      for (int k = 0; k < 4; k++) begin
        b = words[i][31-8*k -: 8];
        x ^= b;
        send(b, gaps, d);
      end
    end
    send(bad ? x ^ 8'h01 : x, gaps, c1);
  endtask
  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_rst"}, {31'd0, CPU_RST}, 32'd1);
    chk({tag, "_cs"}, {31'd0, CS}, 32'd0);
    chk({tag, "_we"}, {31'd0, WE}, 32'd0);
    chk({tag, "_addr"}, {25'd0, ADDR}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, RX_READY}, 32'd0);
    chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
    chk({tag, "_bus_z"}, Mem_Bus, 32'hzzzzzzzz);
  endtask
  initial begin
    int c0, c1, d;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("idle_rdy", {31'd0, RX_READY}, 32'd0);
    // Single word image from the test plan
    words[0] = 32'h20010005;
    pulse_start();
    chk("len_rdy", {31'd0, RX_READY}, 32'd1);
    load(1, 0, 0, c0, c1);
    chk("l1_done", {31'd0, DONE}, 32'd1);
    chk("l1_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    chk("l1_mem0", mem[0], 32'h20010005);
    // Three words back to back: LEN cycle, 15 byte/write cycles, CHK cycle
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    pulse_start();
    chk("restart_done_clr", {31'd0, DONE}, 32'd0);
    chk("restart_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    load(3, 0, 0, c0, c1);
    chk("l3_latency", 32'(c1 - c0 + 1), 32'd17);
    chk("l3_done", {31'd0, DONE}, 32'd1);
    // Bad checksum, then a good reload
    words[0] = $urandom;
    words[1] = $urandom;
    pulse_start();
    load(2, 0, 1, c0, c1);
    chk("badchk_err", {31'd0, ERR}, 32'd1);
    chk("badchk_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    chk("badchk_done", {31'd0, DONE}, 32'd0);
    pulse_start();
    chk("reload_err_clr", {31'd0, ERR}, 32'd0);
    load(2, 0, 0, c0, c1);
    chk("reload_done", {31'd0, DONE}, 32'd1);
    // Length bounds: any CS pulse hits an empty scoreboard
    pulse_start();
    send(8'd0, 0, d);
    chk("len0_err", {31'd0, ERR}, 32'd1);
    chk("len0_rdy", {31'd0, RX_READY}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    pulse_start();
    send(8'd129, 0, d);
    chk("len129_err", {31'd0, ERR}, 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    pulse_start();
    send(8'd128, 0, d);
    chk("len128_accepted", {31'd0, ERR}, 32'd0);
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    // Gapped stream with random START noise mid-load
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      mem[i] = 'x;
    end
    pulse_start();
    load(3, 1, 0, c0, c1);
    chk("gap_done", {31'd0, DONE}, 32'd1);
    for (int i = 0; i < 3; i++) chk("gap_mem", mem[i], words[i]);
    // Reset asserted during the second write
    words[0] = $urandom;
    words[1] = $urandom;
    pulse_start();
    send(8'd3, 0, d);
    for (int i = 0; i < 2; i++) begin
      sb.push_back({7'(i), words[i]});
      for (int k = 0; k < 4; k++) send(words[i][31-8*k -: 8], 0, d);
    end
    chk("w2_cs", {31'd0, CS}, 32'd1);
    chk("w2_addr", {25'd0, ADDR}, 32'd1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    pulse_start();
    load(3, 0, 0, c0, c1);
    chk("post_rst_done", {31'd0, DONE}, 32'd1);
    chk("post_rst_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/mips_loader.md
# mips_loader

Boot loader that sits directly upstream of the instruction/data memory: it receives a program image as a byte stream, packs it into 32-bit big-endian words, and writes them into memory over the shared CS/WE/ADDR/Mem_Bus port. It holds the CPU in reset for the whole load and releases it only after the image checksum verifies. The REG1 LED output becomes meaningful only after this block reports DONE.

## Interface

Parameters:
- ADDR_W, 7, memory word-address width
- DEPTH, 128, number of memory words; maximum image length
- BASE_ADDR, 0, word address of the first image word

Ports:
- CLK  in  1  system clock; all state changes on posedge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  begin a load; sampled in IDLE, DONE and ERR only
- RX_VALID  in  1  byte available on RX_DATA
- RX_DATA  in  8  incoming byte
- RX_READY  out  1  loader accepts a byte this cycle
- CPU_RST  out  1  active-high reset to the CPU; high while not DONE
- CS  out  1  memory chip select
- WE  out  1  memory write enable
- ADDR  out  ADDR_W  memory word address
- Mem_Bus  inout  32  driven only when CS&WE, otherwise high-Z
- DONE  out  1  image loaded and verified
- ERR  out  1  length or checksum failure

## Operation

- Image format: byte L (word count, 1..DEPTH), then 4·L data bytes (MSB first per word), then checksum byte C = XOR of all 4·L data bytes. L itself is not part of C.
- States: IDLE, LEN, BYTE, WRITE, CHK, DONE, ERR.
- IDLE: RX_READY=0, CPU_RST=1. START=1 -> LEN.
- LEN: RX_READY=1. On accept: L=0 or L>DEPTH -> ERR; else store L, word_idx=0, byte_cnt=0, xor_acc=0 -> BYTE.
- BYTE: RX_READY=1. Each accepted byte shifts into the word register (shift left 8), XORs into xor_acc, increments byte_cnt; after the 4th byte -> WRITE.
- WRITE: RX_READY=0; CS=1, WE=1, ADDR=BASE_ADDR+word_idx, Mem_Bus=packed word, held for exactly one cycle. Then word_idx+1; if word_idx was L-1 -> CHK, else byte_cnt=0 -> BYTE.
- CHK: RX_READY=1. On accept: byte==xor_acc -> DONE, else -> ERR.
- DONE: DONE=1, CPU_RST=0. ERR: ERR=1, CPU_RST=1. In both, START=1 -> LEN with DONE/ERR cleared and CPU_RST=1 on the same edge.
- START outside IDLE/DONE/ERR is ignored. RX_VALID without RX_READY is not consumed.
- ADDR wraps modulo 2^ADDR_W; with BASE_ADDR≠0, an image that crosses the top wraps to address 0.

## Timing

- Reset (asynchronous assert, synchronous release): state=IDLE, CPU_RST=1, CS=0, WE=0, ADDR=0, Mem_Bus high-Z, RX_READY=0, DONE=0, ERR=0, all counters 0.
- A byte transfers on a posedge with RX_VALID&RX_READY; the loader accepts one byte per cycle when the source streams back to back.
- CS/WE/ADDR/Mem_Bus are registered and stable for the whole WRITE cycle, so the memory's negedge write samples settled values.
- Minimum load time for L words: 1 (LEN) + 5·L (4 bytes + 1 write) + 1 (CHK) cycles from the first accepted byte to DONE.
- CPU_RST falls on the same posedge on which DONE rises.
- Reset asserted mid-load: outputs return to reset values immediately (CS/WE drop asynchronously). Memory contents written so far are retained but not trusted, and the CPU stays in reset.

## Structure

- Shared package: state encoding (3-bit localparams), checksum width, and the image format constants (bytes per word = 4).
- One sub-module, word_packer: an 8-to-32 shift register with a byte counter and a full flag; it clears on the WRITE cycle.
- The top level holds the FSM, word_idx, xor_acc and the tristate bus driver.

## Test plan

- L=1, bytes 0x20 0x01 0x00 0x05, C=0x24 -> one WRITE with ADDR=0, Mem_Bus=0x20010005; then DONE=1, CPU_RST=0.
- L=3 streamed back to back with a correct C -> writes at ADDR 0,1,2; DONE asserts exactly 17 cycles after the LEN byte is accepted.
- L=2 with C wrong by one bit -> both words written; then ERR=1, CPU_RST stays 1. START then reloads a valid image -> DONE.
- L=0, and separately L=129 -> ERR on the cycle after the LEN accept, with no CS pulse.
- RX_VALID toggled randomly with gaps -> the same memory contents and DONE as the gapless run; RX_READY=0 on every WRITE cycle.
- RST_N pulsed low during the 2nd WRITE -> CS/WE drop within the reset cycle and all outputs take reset values; START then completes a normal load.
